ov7670_tile_pool: RTL and testbench



---
 rtl/ov7670_pool_pkg.sv | 24 ++
 rtl/ov7670_tile_pool.sv | 147 ++++++++++++++
 tb/tb_ov7670_tile_pool.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ov7670_pool_pkg.sv
// Shared definitions for the OV7670 tile pooling block.
// Holds the default frame geometry, the accumulator width derivation and the
// pooling FSM state type. No ports; imported with ov7670_pool_pkg::*.
package ov7670_pool_pkg;

    localparam int unsigned IMG_W_DEFAULT     = 640;
    localparam int unsigned IMG_H_DEFAULT     = 480;
    localparam int unsigned TILE_LOG2_DEFAULT = 4;

    // A tile holds 2^(2*tile_log2) bytes, so this width can never overflow.
    function automatic int unsigned acc_width(input int unsigned tile_log2);
        return 8 + 2 * tile_log2;
    endfunction

    localparam int unsigned ACC_W_DEFAULT = acc_width(TILE_LOG2_DEFAULT);

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        ACTIVE,
        DONE
    } pool_state_t;

endpackage

// File: rtl/ov7670_tile_pool.sv
// Average-pools a raster-order pixel byte stream into one byte per
// 2^TILE_LOG2 x 2^TILE_LOG2 tile and writes the pooled image out.
// Ports:
//   pclk, rst_n       pixel clock, asynchronous active-low reset
//   vsync             high = blanking / frame restart
//   pix_valid         one strobe per pixel
//   pix_data          pixel byte
//   out_we            one-cycle write strobe per pooled pixel
//   out_addr          pooled pixel address, ty*OUT_W+tx
//   out_data          tile mean, truncated
//   frame_done        pulse with the final pooled write of a frame
//   frame_err         pulse when vsync aborts a partially received frame
module ov7670_tile_pool
    import ov7670_pool_pkg::*;
#(
    parameter int unsigned IMG_W     = IMG_W_DEFAULT,
    parameter int unsigned IMG_H     = IMG_H_DEFAULT,
    parameter int unsigned TILE_LOG2 = TILE_LOG2_DEFAULT,
    parameter int unsigned OADDR_W   = 11
) (
    input  logic               pclk,
    input  logic               rst_n,
    input  logic               vsync,
    input  logic               pix_valid,
    input  logic [7:0]         pix_data,
    output logic               out_we,
    output logic [OADDR_W-1:0] out_addr,
    output logic [7:0]         out_data,
    output logic               frame_done,
    output logic               frame_err
);

    localparam int unsigned OUT_W = IMG_W >> TILE_LOG2;
    localparam int unsigned ACC_W = acc_width(TILE_LOG2);
    localparam int unsigned PX_W  = $clog2(IMG_W);
    localparam int unsigned PY_W  = $clog2(IMG_H);

    pool_state_t state_q, state_d;

    logic [PX_W-1:0]    px_q;
    logic [PY_W-1:0]    py_q;
    logic [OADDR_W-1:0] oidx_q;
    logic               seen_q;  // at least one pixel accepted this frame
    logic [ACC_W-1:0]   acc_q [OUT_W];

    logic                  accept;
    logic                  last_col;
    logic                  last_pix;
    logic                  tile_end;
    logic                  abort;
    logic [PX_W-TILE_LOG2-1:0] tx;
    logic [TILE_LOG2-1:0]  cx;
    logic [TILE_LOG2-1:0]  cy;
    logic [ACC_W-1:0]      acc_sum;

    assign tx       = px_q[PX_W-1:TILE_LOG2];
    assign cx       = px_q[TILE_LOG2-1:0];
    assign cy       = py_q[TILE_LOG2-1:0];
    assign accept   = (state_q == ACTIVE) && pix_valid && !vsync;
    assign last_col = (px_q == PX_W'(IMG_W - 1));
    assign last_pix = last_col && (py_q == PY_W'(IMG_H - 1));
    assign tile_end = accept && (&cx) && (&cy);
    assign abort    = (state_q == ACTIVE) && vsync && seen_q;
    // First pixel of a tile reloads the column accumulator instead of adding.
    assign acc_sum  = ((cx == '0) && (cy == '0)) ? ACC_W'(pix_data)
                                                 : acc_q[tx] + ACC_W'(pix_data);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (vsync) state_d = SYNC;
            SYNC:    if (!vsync) state_d = ACTIVE;
            ACTIVE: begin
                if (vsync) begin
                    state_d = SYNC;
                end else if (accept && last_pix) begin
                    state_d = DONE;
                end
            end
            DONE:    if (vsync) state_d = SYNC;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            px_q   <= '0;
            py_q   <= '0;
            oidx_q <= '0;
            seen_q <= 1'b0;
        end else if (state_q == SYNC) begin
            px_q   <= '0;
            py_q   <= '0;
            oidx_q <= '0;
            seen_q <= 1'b0;
        end else if (accept) begin
            seen_q <= 1'b1;
            if (last_col) begin
                px_q <= '0;
                py_q <= py_q + PY_W'(1);
            end else begin
                px_q <= px_q + PX_W'(1);
            end
            // Tiles finish in raster order, so a running index is the address.
            if (tile_end) begin
                oidx_q <= oidx_q + OADDR_W'(1);
            end
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(OUT_W); i++) begin
                acc_q[i] <= '0;
            end
        end else if (accept) begin
            acc_q[tx] <= acc_sum;
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            out_we     <= 1'b0;
            out_addr   <= '0;
            out_data   <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            out_we     <= tile_end;
            frame_done <= tile_end && last_pix;
            frame_err  <= abort;
            if (tile_end) begin
                out_addr <= oidx_q;
                out_data <= acc_sum[ACC_W-1:2*TILE_LOG2];
            end
        end
    end

endmodule

// File: tb/tb_ov7670_tile_pool.sv
// Self-checking bench for ov7670_tile_pool on a reduced 272x32 frame
// (17x2 tiles) so that whole frames fit a short run; 272 columns keep the
// byte wrap of the ramp pattern at column 256 inside one frame.
module tb_ov7670_tile_pool;

    localparam int W     = 272;
    localparam int H     = 32;
    localparam int TL    = 4;
    localparam int TS    = 16;
    localparam int OW    = W / TS;
    localparam int NPIX  = W * H;
    localparam int NTILE = (W / TS) * (H / TS);

    logic        pclk = 1'b0;
    logic        rst_n;
    logic        vsync;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        out_we;
    logic [10:0] out_addr;
    logic [7:0]  out_data;
    logic        frame_done;
    logic        frame_err;

    typedef struct {
        logic [10:0] addr;
        logic [7:0]  data;
        logic        done;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   err_pulses  = 0;
    int   done_pulses = 0;
    int   writes      = 0;

    ov7670_tile_pool #(
        .IMG_W     (W),
        .IMG_H     (H),
        .TILE_LOG2 (TL),
        .OADDR_W   (11)
    ) dut (
        .pclk       (pclk),
        .rst_n      (rst_n),
        .vsync      (vsync),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .out_we     (out_we),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always #5 pclk = ~pclk;

    function automatic logic [7:0] pat(input int id, input int x, input int y);
        logic [7:0] v;
        case (id)
            0:       v = 8'h80;
            1:       v = x[7:0];
            2:       v = (x < TS && y < TS) ? 8'hFF : 8'h00;
            3:       v = 8'((x * 7 + y * 13) ^ (x >> 3));
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    function automatic int tile_mean(input int id, input int tx, input int ty);
        int sum = 0;
        for (int y = ty * TS; y < (ty + 1) * TS; y++) begin
            for (int x = tx * TS; x < (tx + 1) * TS; x++) begin
                sum += int'(pat(id, x, y));
            end
        end
        return sum / (TS * TS);
    endfunction

    // Scoreboard: pop one expectation per observed write.
    always @(negedge pclk) begin
        if (frame_err) err_pulses++;
        if (frame_done) done_pulses++;
        if (out_we) begin
            exp_t e;
            writes++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr=%0d data=%02h, required no write",
                         out_addr, out_data);
            end else begin
                e = exp_q.pop_front();
                if (out_addr !== e.addr || out_data !== e.data || frame_done !== e.done) begin
                    n_fail++;
                    $display("FAIL pooled_write: got addr=%0d data=%02h done=%b, required addr=%0d data=%02h done=%b",
                             out_addr, out_data, frame_done, e.addr, e.data, e.done);
                end
            end
        end else if (frame_done) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_without_we: got frame_done=1 with out_we=0, required 0");
        end
    end

    task automatic vsync_pulse(input bit junk);
        vsync = 1'b1;
        for (int i = 0; i < 4; i++) begin
            // Pixels strobed during vsync must be dropped.
            pix_valid = junk && i[0];
            pix_data  = 8'h5A;
            @(posedge pclk);
            #1;
        end
        pix_valid = 1'b0;
        vsync     = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
    endtask

    task automatic send_pixels(input int id, input int n, input int gap, input bit model);
        for (int i = 0; i < n; i++) begin
            int x;
            int y;
            exp_t e;
            x = i % W;
            y = i / W;
            pix_valid = 1'b1;
            pix_data  = (i < NPIX) ? pat(id, x, y) : 8'($urandom);
            if (model && i < NPIX && (x % TS) == TS - 1 && (y % TS) == TS - 1) begin
                e.addr = 11'((y / TS) * OW + x / TS);
                e.data = 8'(tile_mean(id, x / TS, y / TS));
                e.done = (i == NPIX - 1);
                exp_q.push_back(e);
            end
            @(posedge pclk);
            #1;
            pix_valid = 1'b0;
            repeat (gap) begin
                @(posedge pclk);
                #1;
            end
        end
    endtask

    task automatic drain_check(input string name, input int exp_err, input int exp_done,
                               input int exp_writes);
        repeat (4) @(posedge pclk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_missing_writes: got %0d outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        n_checks++;
        if (err_pulses != exp_err) begin
            n_fail++;
            $display("FAIL %s_frame_err: got %0d pulses, required %0d", name, err_pulses, exp_err);
        end
        n_checks++;
        if (done_pulses != exp_done) begin
            n_fail++;
            $display("FAIL %s_frame_done: got %0d pulses, required %0d", name, done_pulses,
                     exp_done);
        end
        n_checks++;
        if (writes != exp_writes) begin
            n_fail++;
            $display("FAIL %s_write_count: got %0d, required %0d", name, writes, exp_writes);
        end
        err_pulses  = 0;
        done_pulses = 0;
        writes      = 0;
    endtask

    task automatic check_outputs_zero(input string name);
        n_checks++;
        if (out_we !== 1'b0 || out_addr !== 11'd0 || out_data !== 8'd0 ||
            frame_done !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got we=%b addr=%0d data=%02h done=%b err=%b, required all 0",
                     name, out_we, out_addr, out_data, frame_done, frame_err);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        check_outputs_zero("reset_values");
        repeat (2) @(posedge pclk);
        #1;
        rst_n = 1'b1;
        // Idle: a full tile row of pixels before any vsync must be ignored.
        send_pixels(0, W * TS, 0, 1'b0);
        drain_check("idle_ignore", 0, 0, 0);
    endtask

    task automatic test_const_frame();
        vsync_pulse(1'b1);
        send_pixels(0, NPIX, 1, 1'b1);
        drain_check("const_frame", 0, 1, NTILE);
    endtask

    task automatic test_ramp();
        vsync_pulse(1'b1);
        send_pixels(1, NPIX, 0, 1'b1);
        drain_check("ramp", 0, 1, NTILE);
    endtask

    task automatic test_tile0();
        vsync_pulse(1'b0);
        send_pixels(2, NPIX, 0, 1'b1);
        drain_check("tile0", 0, 1, NTILE);
    endtask

    task automatic test_abort();
        vsync_pulse(1'b0);
        send_pixels(3, 1000, 0, 1'b1);
        vsync_pulse(1'b0);
        drain_check("abort", 1, 0, 0);
        send_pixels(3, NPIX, 0, 1'b1);
        drain_check("after_abort", 0, 1, NTILE);
    endtask

    task automatic test_overrun();
        vsync_pulse(1'b0);
        send_pixels(3, NPIX + 300, 0, 1'b1);
        drain_check("overrun", 0, 1, NTILE);
        vsync_pulse(1'b0);
        drain_check("overrun_vsync", 0, 0, 0);
        send_pixels(0, NPIX, 0, 1'b1);
        drain_check("overrun_next", 0, 1, NTILE);
    endtask

    task automatic test_mid_reset();
        vsync_pulse(1'b0);
        send_pixels(3, 5000, 0, 1'b1);
        repeat (2) @(posedge pclk);
        #1;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("mid_reset_outputs");
        drain_check("pre_reset", 0, 0, OW);
        @(posedge pclk);
        #1;
        rst_n = 1'b1;
        send_pixels(3, W * TS, 0, 1'b0);
        drain_check("post_reset_idle", 0, 0, 0);
        vsync_pulse(1'b0);
        send_pixels(1, NPIX, 0, 1'b1);
        drain_check("post_reset_frame", 0, 1, NTILE);
    endtask

    initial begin
        rst_n     = 1'b0;
        vsync     = 1'b0;
        pix_valid = 1'b0;
        pix_data  = 8'h00;
        test_reset();
        test_const_frame();
        test_ramp();
        test_tile0();
        test_abort();
        test_overrun();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
